// File: rtl/minmax_pkg.sv
// minmax_pkg: shared types and default widths for the min/max tracker.
//   state_t       - sequencer states
//   MM_DATA_W     - default sample/result width
//   MM_LEN_W      - default burst-length / counter width
package minmax_pkg;

  localparam int MM_DATA_W = 16;
  localparam int MM_LEN_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    CMP_MAX,
    CMP_MIN,
    DONE
  } state_t;

endpackage

// File: rtl/minmax_cmp.sv
// minmax_cmp: combinational unsigned magnitude compare, shared by the
// max and min passes of the tracker.
//   i_a, i_b : operands (unsigned)
//   o_gt     : i_a >  i_b
//   o_lt     : i_a <  i_b
//   o_eq     : i_a == i_b
module minmax_cmp
  import minmax_pkg::*;
#(
  parameter int W = MM_DATA_W
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_gt,
  output logic         o_lt,
  output logic         o_eq
);

  assign o_gt = (i_a >  i_b);
  assign o_lt = (i_a <  i_b);
  assign o_eq = (i_a == i_b);

endmodule

// File: rtl/minmax_tracker.sv
// minmax_tracker: running max/min of a burst of unsigned samples using one
// time-multiplexed compare unit (CMP_MAX cycle, then CMP_MIN cycle).
//   clk, n_rst           : clock, async active-low reset
//   start, burst_len     : begin a burst of burst_len samples (IDLE only)
//   in_data/in_valid/in_ready : sample stream handshake
//   busy                 : not IDLE
//   done                 : one-cycle pulse, results final
//   err                  : one-cycle pulse, start with burst_len == 0
//   max_val, min_val     : running / final results
//   max_idx, min_idx     : 0-based position of the held max/min sample,
//                          present only when MINMAX_INDEX_EN is defined
module minmax_tracker
  import minmax_pkg::*;
#(
  parameter int DATA_W = MM_DATA_W,
  parameter int LEN_W  = MM_LEN_W
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] max_val,
  output logic [DATA_W-1:0] min_val
`ifdef MINMAX_INDEX_EN
  ,
  output logic [LEN_W-1:0]  max_idx,
  output logic [LEN_W-1:0]  min_idx
`endif
);

  state_t              r_state;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_sample;
  logic [DATA_W-1:0]   r_max;
  logic [DATA_W-1:0]   r_min;
  logic                r_err;
`ifdef MINMAX_INDEX_EN
  logic [LEN_W-1:0]    r_max_idx;
  logic [LEN_W-1:0]    r_min_idx;
`endif

  logic [DATA_W-1:0]   w_op_b;
  logic                w_gt;
  logic                w_lt;
  logic                w_eq;
  logic [LEN_W-1:0]    w_cnt_inc;

  // r_cnt < r_len whenever it is incremented, so this never wraps even
  // for the largest representable burst length.
  assign w_cnt_inc = r_cnt + LEN_W'(1);

  // Operand mux: sample is always operand a; b follows the compare phase.
  assign w_op_b = (r_state == CMP_MIN) ? r_min : r_max;

  minmax_cmp #(.W(DATA_W)) u_cmp (
    .i_a  (r_sample),
    .i_b  (w_op_b),
    .o_gt (w_gt),
    .o_lt (w_lt),
    .o_eq (w_eq)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= IDLE;
      r_len     <= '0;
      r_cnt     <= '0;
      r_sample  <= '0;
      r_max     <= '0;
      r_min     <= '0;
      r_err     <= 1'b0;
`ifdef MINMAX_INDEX_EN
      r_max_idx <= '0;
      r_min_idx <= '0;
`endif
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (burst_len != '0) begin
              r_len   <= burst_len;
              r_cnt   <= '0;
              r_state <= WAIT;
            end else begin
              r_err   <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (in_valid) begin
            r_sample <= in_data;
            if (r_cnt == '0) begin
              // First sample seeds both results directly, no compare needed.
              r_max   <= in_data;
              r_min   <= in_data;
`ifdef MINMAX_INDEX_EN
              r_max_idx <= '0;
              r_min_idx <= '0;
`endif
              r_cnt   <= LEN_W'(1);
              r_state <= (r_len == LEN_W'(1)) ? DONE : WAIT;
            end else begin
              r_state <= CMP_MAX;
            end
          end
        end
        CMP_MAX: begin
          // Ties keep the earlier holder.
          if (!w_eq && w_gt) begin
            r_max <= r_sample;
`ifdef MINMAX_INDEX_EN
            r_max_idx <= r_cnt;
`endif
          end
          r_state <= CMP_MIN;
        end
        CMP_MIN: begin
          if (!w_eq && w_lt) begin
            r_min <= r_sample;
`ifdef MINMAX_INDEX_EN
            r_min_idx <= r_cnt;
`endif
          end
          r_cnt   <= w_cnt_inc;
          r_state <= (w_cnt_inc == r_len) ? DONE : WAIT;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Status outputs are pure decodes of the state register.
  assign in_ready = (r_state == WAIT);
  assign busy     = (r_state != IDLE);
  assign done     = (r_state == DONE);
  assign err      = r_err;
  assign max_val  = r_max;
  assign min_val  = r_min;
`ifdef MINMAX_INDEX_EN
  assign max_idx  = r_max_idx;
  assign min_idx  = r_min_idx;
`endif

endmodule

// File: tb/tb_minmax_tracker.sv
module tb_minmax_tracker;
  localparam int DW = 16;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] burst_len = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready, busy, done, err;
  logic [DW-1:0] max_val, min_val;
`ifdef MINMAX_INDEX_EN
  logic [LW-1:0] max_idx, min_idx;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  minmax_tracker #(.DATA_W(DW), .LEN_W(LW)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .burst_len (burst_len),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .max_val   (max_val),
    .min_val   (min_val)
`ifdef MINMAX_INDEX_EN
    ,
    .max_idx   (max_idx),
    .min_idx   (min_idx)
`endif
  );

  // Stimulus helpers (called at a negedge, return at a negedge).
  task automatic do_start(input logic [LW-1:0] len);
    start = 1'b1; burst_len = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push(input logic [DW-1:0] d);
    int n = 0;
    in_valid = 1'b1; in_data = d;
    while (!in_ready && n < 30) begin @(negedge clk); n++; end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL push_accept: in_ready=%b required 1 for data %h", in_ready, d);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({in_ready, busy, done, err, max_val, min_val} !== '0) begin
      errors++; $display("FAIL reset_init: rdy=%b busy=%b done=%b err=%b max=%h min=%h required all 0",
                         in_ready, busy, done, err, max_val, min_val);
    end
    n_rst = 1'b1;
    @(negedge clk);
    do_start(8'd5);
    push(16'h0100);
    push(16'h0200);
    // Mid-burst reset: outputs must drop without waiting for a clock edge.
    n_rst = 1'b0;
    #1;
    checks++;
    if ({in_ready, busy, done, err, max_val, min_val} !== '0) begin
      errors++; $display("FAIL reset_mid: rdy=%b busy=%b done=%b err=%b max=%h min=%h required all 0",
                         in_ready, busy, done, err, max_val, min_val);
    end
    n = 0;
    for (int i = 0; i < 3; i++) begin @(negedge clk); if (done) n++; end
    n_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin @(negedge clk); if (done) n++; end
    checks++;
    if (n != 0) begin errors++; $display("FAIL reset_no_done: saw %0d done cycles required 0", n); end
    do_start(8'd1);
    push(16'h0055);
    checks++;
    if (done !== 1'b1 || max_val !== 16'h0055 || min_val !== 16'h0055) begin
      errors++; $display("FAIL reset_after_len1: done=%b max=%h min=%h required 1/0055/0055", done, max_val, min_val);
    end
    @(negedge clk);
  endtask

  task automatic test_burst5();
    int n = 0;
    do_start(8'd5);
    push(16'h0010); push(16'hFFFF); push(16'h0000); push(16'h8000); push(16'h0010);
    while (!done && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (done !== 1'b1 || n != 2) begin
      errors++; $display("FAIL b5_done: done=%b after %0d cycles required 1 after 2", done, n);
    end
    checks++;
    if (max_val !== 16'hFFFF || min_val !== 16'h0000) begin
      errors++; $display("FAIL b5_vals: max=%h min=%h required FFFF/0000", max_val, min_val);
    end
`ifdef MINMAX_INDEX_EN
    checks++;
    if (max_idx !== 8'd1 || min_idx !== 8'd2) begin
      errors++; $display("FAIL b5_idx: max_idx=%0d min_idx=%0d required 1/2", max_idx, min_idx);
    end
`endif
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL b5_pulse: done=%b busy=%b required 0/0", done, busy);
    end
  endtask

  task automatic test_ties();
    int n = 0;
    do_start(8'd3);
    push(16'h1234); push(16'h1234); push(16'h1234);
    while (!done && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (done !== 1'b1 || max_val !== 16'h1234 || min_val !== 16'h1234) begin
      errors++; $display("FAIL ties_vals: done=%b max=%h min=%h required 1/1234/1234", done, max_val, min_val);
    end
`ifdef MINMAX_INDEX_EN
    checks++;
    if (max_idx !== 8'd0 || min_idx !== 8'd0) begin
      errors++; $display("FAIL ties_idx: max_idx=%0d min_idx=%0d required 0/0", max_idx, min_idx);
    end
`endif
    @(negedge clk);
  endtask

  // in_valid held high the whole burst with junk data between transfers.
  task automatic test_back_to_back();
    logic [DW-1:0] vals [4];
    int xfers = 0, done_cyc = 0, mask = 0;
    vals[0] = 16'h0005; vals[1] = 16'h0009; vals[2] = 16'h0001; vals[3] = 16'h0007;
    do_start(8'd4);
    in_valid = 1'b1;
    for (int cyc = 1; cyc < 40; cyc++) begin
      if (done) begin done_cyc = cyc; break; end
      if (in_ready) begin
        mask = mask | (1 << cyc);
        in_data = (xfers < 4) ? vals[xfers] : 16'h4444;
        xfers++;
      end else begin
        in_data = cyc[0] ? 16'hFFFF : 16'h0000;
      end
      @(negedge clk);
    end
    checks++;
    if (xfers != 4) begin errors++; $display("FAIL bp_xfers: got %0d transfers required 4", xfers); end
    checks++;
    if (mask != 294) begin errors++; $display("FAIL bp_ready_pattern: mask=%0h required %0h", mask, 294); end
    checks++;
    if (done_cyc != 11) begin errors++; $display("FAIL bp_done_cycle: got %0d required 11", done_cyc); end
    checks++;
    if (max_val !== 16'h0009 || min_val !== 16'h0001) begin
      errors++; $display("FAIL bp_vals: max=%h min=%h required 0009/0001", max_val, min_val);
    end
`ifdef MINMAX_INDEX_EN
    checks++;
    if (max_idx !== 8'd1 || min_idx !== 8'd2) begin
      errors++; $display("FAIL bp_idx: max_idx=%0d min_idx=%0d required 1/2", max_idx, min_idx);
    end
`endif
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL bp_pulse: done=%b required 0", done); end
  endtask

  task automatic test_zero_len();
    do_start(8'd0);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL zl_err: err=%b busy=%b required 1/0", err, busy);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL zl_after: err=%b busy=%b rdy=%b required 0/0/0", err, busy, in_ready);
    end
    checks++;
    if (max_val !== 16'h0009 || min_val !== 16'h0001) begin
      errors++; $display("FAIL zl_hold: max=%h min=%h required 0009/0001", max_val, min_val);
    end
  endtask

  task automatic test_len1_busy_start();
    int n = 0;
    do_start(8'd1);
    push(16'hABCD);
    checks++;
    if (done !== 1'b1 || max_val !== 16'hABCD || min_val !== 16'hABCD) begin
      errors++; $display("FAIL l1_done: done=%b max=%h min=%h required 1/ABCD/ABCD", done, max_val, min_val);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL l1_pulse: done=%b busy=%b required 0/0", done, busy);
    end
    do_start(8'd3);
    push(16'h0003);
    push(16'h0001);
    // Now in CMP_MAX: a start here must not restart the burst.
    start = 1'b1; burst_len = 8'd1;
    @(negedge clk);
    start = 1'b0; burst_len = 8'd0;
    push(16'h0002);
    while (!done && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (done !== 1'b1 || max_val !== 16'h0003 || min_val !== 16'h0001) begin
      errors++; $display("FAIL busy_start: done=%b max=%h min=%h required 1/0003/0001", done, max_val, min_val);
    end
`ifdef MINMAX_INDEX_EN
    checks++;
    if (max_idx !== 8'd0 || min_idx !== 8'd1) begin
      errors++; $display("FAIL busy_start_idx: max_idx=%0d min_idx=%0d required 0/1", max_idx, min_idx);
    end
`endif
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_burst5();
    test_ties();
    test_back_to_back();
    test_zero_len();
    test_len1_busy_start();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/minmax_tracker.md
# minmax_tracker

Sequencer that finds the running maximum and minimum of a burst of 16-bit samples using a single shared magnitude-compare unit. The unit is time-multiplexed: one cycle compares against the current max, the next against the current min. The block sits between a valid/ready sample source and downstream logic that consumes a `done` pulse plus the max/min results.

## Interface
- `DATA_W`, default 16: sample and result width.
- `LEN_W`, default 8: width of the burst-length input and sample counter.
- `clk` in, 1: rising-edge clock.
- `n_rst` in, 1: reset, asynchronous and active-low.
- `start` in, 1: begin a burst; sampled only in IDLE.
- `burst_len` in, LEN_W: number of samples in the burst, latched on accepted `start`.
- `in_data` in, DATA_W: sample value.
- `in_valid` in, 1: `in_data` is valid.
- `in_ready` out, 1: block accepts a sample this cycle.
- `busy` out, 1: high in every state except IDLE.
- `done` out, 1: single-cycle pulse when results are final.
- `err` out, 1: single-cycle pulse when `start` arrives with `burst_len == 0`.
- `max_val` out, DATA_W: running/final maximum.
- `min_val` out, DATA_W: running/final minimum.
- `max_idx`, `min_idx` out, LEN_W: present only with `MINMAX_INDEX_EN`.

## Operation
- States: IDLE, WAIT, CMP_MAX, CMP_MIN, DONE.
- IDLE: if `start` and `burst_len != 0`: latch length, clear count, go to WAIT. If `start` and `burst_len == 0`: pulse `err`, stay in IDLE.
- WAIT: `in_ready = 1`. On `in_valid`:
  - capture `in_data` into the sample register;
  - if count == 0 (first sample): load `max_val` and `min_val` with the sample, count = 1, then go to DONE if length == 1, else stay in WAIT;
  - otherwise go to CMP_MAX.
- CMP_MAX: compare unit operands are (a = sample, b = `max_val`). If a > b, load `max_val` with the sample. Go to CMP_MIN.
- CMP_MIN: operands are (a = sample, b = `min_val`). If a < b, load `min_val` with the sample. Increment count; go to DONE if count + 1 == length, else WAIT.
- DONE: `done = 1` for one cycle, then IDLE. Results hold until the next accepted `start`; they are not cleared at that point and are overwritten by the first sample.
- Comparison is unsigned. Ties never update a result, so the first occurrence wins.
- `start` outside IDLE is ignored. `in_valid` outside WAIT is ignored (`in_ready` is 0).
- Reset values: state IDLE; `in_ready`, `busy`, `done`, `err` = 0; `max_val`, `min_val`, and the indices = 0; count = 0.

## Timing
- `start` to `in_ready` high: 1 cycle.
- First sample: accepted in 1 cycle.
- Each later sample occupies 3 cycles (WAIT accept, CMP_MAX, CMP_MIN). Peak throughput is 1 sample per 3 cycles.
- `done` is asserted the cycle after the final CMP_MIN, or the cycle after acceptance for a length-1 burst.
- `max_val` and `min_val` are valid in the `done` cycle.
- The source may hold `in_valid` high with changing data. A sample transfers only when `in_valid && in_ready`.
- Reset asserted mid-burst forces IDLE and all reset values immediately. No `done` is produced.
- `burst_len` = 2^LEN_W − 1 must complete without counter wrap.

## Configuration
- `MINMAX_INDEX_EN` defined:
  - adds outputs `max_idx` and `min_idx`;
  - each holds the 0-based position of the sample currently held in `max_val` / `min_val`;
  - each is loaded together with its value, set to 0 on the first sample and on reset.
- `MINMAX_INDEX_EN` undefined: the ports and their registers are absent. All other behaviour is identical.

## Structure
- Package `minmax_pkg`:
  - state enum (IDLE, WAIT, CMP_MAX, CMP_MIN, DONE);
  - `DATA_W` and `LEN_W` default constants.
- Sub-module `minmax_cmp`:
  - combinational unsigned compare with outputs gt/lt/eq;
  - instantiated once;
  - operand mux driven by the state machine.
- The top level holds the state register, counter, sample register, result registers and the operand mux.

## Test plan
- Reset: assert `n_rst` = 0 mid-burst → all outputs 0, `busy` = 0 in the same cycle. After release, `start` with `burst_len` = 1 succeeds.
- Burst 5: samples 0x0010, 0xFFFF, 0x0000, 0x8000, 0x0010 → `done` pulse with `max_val` = 0xFFFF and `min_val` = 0x0000. With index enabled, `max_idx` = 1 and `min_idx` = 2.
- Ties: burst 3 of 0x1234 repeated → `max_val` = `min_val` = 0x1234. With index enabled, both indices = 0.
- Back-pressure: `in_valid` held high continuously for a 4-sample burst → `in_ready` high 1 cycle in every 3. Exactly 4 transfers, then `done` at the expected cycle.
- Zero length: `start` with `burst_len` = 0 → `err` pulse, state stays IDLE, `busy` = 0, results unchanged.
- Length 1 and `start` while busy: burst 1 of 0xABCD → `done` one cycle after acceptance with max = min = 0xABCD. A `start` pulse during a 3-sample burst is ignored.
